regional_bus_arbiter: RTL and testbench
=======================================

// Module: regional_bus_arbiter
// PURPOSE
//  Round-robin arbiter sharing the single-master regional peripheral bus (req/we/addr/data/ack)
//  between NM requesters (core data port, DMA, debug). Sits directly in front of the regional
//  decoder. Grants one master at a time and latches that master's command for the slave.
//  Returns read data and a one-cycle ack to the granted master.
// PARAMETERS
//  NM          3    number of masters, 2..8
//  TIMEOUT_CYC 256  cycles in BUSY without s_ack_i before forced error response (RBA_TIMEOUT_EN only)
// PORTS
//  clk       in   1      clock
//  rst       in   1      async reset, active-low
//  m_req_i   in   NM     per-master request, held high until its m_ack_o pulse
//  m_we_i    in   NM     per-master write enable (1=write)
//  m_addr_i  in   NM*32  per-master address, master k at [32k+31:32k]
//  m_data_i  in   NM*32  per-master write data, same packing
//  m_data_o  out  32     read data, shared, valid when any m_ack_o bit is high
//  m_ack_o   out  NM     one-cycle completion pulse to the granted master
//  m_err_o   out  NM     one-cycle error pulse, coincident with m_ack_o
//  s_req_o   out  1      slave request
//  s_we_o    out  1      slave write enable
//  s_addr_o  out  32     slave address
//  s_data_o  out  32     slave write data
//  s_data_i  in   32     slave read data, valid with s_ack_i
//  s_ack_i   in   1      slave ack; may be combinational in the same cycle as s_req_o
// BEHAVIOUR
//  - Reset (rst=0, async): state=IDLE, ptr=0, grant=0, all outputs 0, timeout counter 0.
//  - FSM: IDLE -> BUSY -> RESP -> IDLE.
//  - IDLE: if any m_req_i is high, choose the first requester searching ptr, ptr+1, ... with
//    wrap modulo NM. Latch grant index g and its we/addr/data into s_*_o registers.
//    Go to BUSY. With no request, stay in IDLE; s_req_o=0.
//  - BUSY: s_req_o=1; s_we_o/s_addr_o/s_data_o hold the latched values, stable even if
//    master inputs change. When s_ack_i=1, register s_data_i into m_data_o and go to RESP.
//    Writes return m_data_o = s_data_i as presented; masters ignore it.
//  - RESP: m_ack_o[g]=1 for exactly one cycle; s_req_o=0; ptr <= (g+1) mod NM; go to IDLE.
//    m_data_o holds until the next RESP. m_ack_o is 0 in all other states.
//  - Latency: a request seen in IDLE at cycle 0 gives s_req_o at cycle 1. A same-cycle slave
//    ack gives m_ack_o at cycle 2. Minimum 3 cycles per transfer; back-to-back grants start at
//    cycle 3.
//  - Master rule: after seeing m_ack_o, deassert m_req_i for at least the next cycle, or
//    present a new command. IDLE then re-arbitrates with the updated ptr.
//  - Request dropped while granted: protocol violation. The latched transfer still completes
//    and the ack is still pulsed; no recovery or flagging.
//  - Fairness: after master g completes, g has lowest priority. With all NM requesting
//    continuously, grants rotate 0,1,..,NM-1,0.
//  - ptr and g are $clog2(NM) bits; wrap from NM-1 to 0, including non-power-of-2 NM.
// CONFIGURATION
//  RBA_TIMEOUT_EN defined:
//  - 16-bit counter clears on entry to BUSY and increments each BUSY cycle without s_ack_i.
//  - When count == TIMEOUT_CYC-1 and s_ack_i=0: go to RESP with m_data_o=32'h0 and
//    m_err_o[g]=1 together with m_ack_o[g].
//  - If s_ack_i=1 in that same cycle, the ack wins: normal response, no error.
//  RBA_TIMEOUT_EN undefined:
//  - No counter; BUSY waits indefinitely for s_ack_i.
//  - m_err_o is tied to 0.
// TESTING
//  1. Reset mid-BUSY (rst low for 1 cycle): all outputs 0 immediately. Next request from
//     m1 is granted normally with ptr=0 search.
//  2. Single read, m0 addr 0x1000_0004, slave acks in the same cycle with 0xA5A5_0001:
//     s_req_o high cycle 1; m_ack_o=3'b001 and m_data_o=0xA5A5_0001 at cycle 2.
//  3. All 3 masters request continuously, writes, slave acks immediately: grant order
//     0,1,2,0,1,2; one ack every 3 cycles; s_addr_o/s_data_o match the granted master.
//  4. m2 requests while m0 is in BUSY and m0 re-requests after its ack: m2 is granted before
//     m0. Changing m0's addr during BUSY does not change s_addr_o.
//  5. RBA_TIMEOUT_EN, TIMEOUT_CYC=8, slave never acks: m_ack_o and m_err_o pulse for the
//     granted master 8 cycles after s_req_o rises, with m_data_o=0.
//  6. RBA_TIMEOUT_EN, s_ack_i first asserted in the terminal count cycle: m_ack_o without
//     m_err_o; m_data_o=s_data_i.

Source files
------------

// File: rtl/regional_bus_arbiter.sv
// -----------------------------------------------------------------------------
// regional_bus_arbiter
//
// Round-robin arbiter in front of the regional peripheral decoder. Shares the
// single-master regional bus between NM requesters (core data port, DMA,
// debug). One master is granted at a time; its command is latched onto the
// slave side and held stable until the slave acks. Read data and a one-cycle
// ack pulse are then returned to the granted master.
//
// Sequence per transfer: IDLE (arbitrate + latch) -> BUSY (s_req_o high,
// wait for s_ack_i) -> RESP (m_ack_o pulse, advance pointer) -> IDLE.
// The master just served becomes lowest priority for the next arbitration.
//
// Optional feature (macro RBA_TIMEOUT_EN):
//   When defined, a 16-bit counter watches BUSY. If the slave has not acked
//   by the TIMEOUT_CYC-th BUSY cycle, the transfer is terminated with
//   m_data_o = 0 and m_err_o pulsed together with m_ack_o. An ack arriving in
//   that final cycle still wins. When undefined, BUSY waits forever and
//   m_err_o is tied low.
//
// Parameters:
//   NM          number of masters (2..8)
//   TIMEOUT_CYC BUSY cycles before a forced error response (RBA_TIMEOUT_EN)
//
// Ports:
//   clk        clock
//   rst        asynchronous reset, active low
//   m_req_i    per-master request, held until that master's ack
//   m_we_i     per-master write enable
//   m_addr_i   per-master address, master k at [32k+31:32k]
//   m_data_i   per-master write data, same packing
//   m_data_o   shared read data, valid while any m_ack_o bit is high
//   m_ack_o    one-cycle completion pulse to the granted master
//   m_err_o    one-cycle error pulse, coincident with m_ack_o
//   s_req_o    slave request (high throughout BUSY)
//   s_we_o     slave write enable (latched)
//   s_addr_o   slave address (latched)
//   s_data_o   slave write data (latched)
//   s_data_i   slave read data, valid with s_ack_i
//   s_ack_i    slave ack, may be combinational on s_req_o
// -----------------------------------------------------------------------------
module regional_bus_arbiter #(
  parameter int NM          = 3,
  parameter int TIMEOUT_CYC = 256
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [NM-1:0]    m_req_i,
  input  logic [NM-1:0]    m_we_i,
  input  logic [NM*32-1:0] m_addr_i,
  input  logic [NM*32-1:0] m_data_i,
  output logic [31:0]      m_data_o,
  output logic [NM-1:0]    m_ack_o,
  output logic [NM-1:0]    m_err_o,
  output logic             s_req_o,
  output logic             s_we_o,
  output logic [31:0]      s_addr_o,
  output logic [31:0]      s_data_o,
  input  logic [31:0]      s_data_i,
  input  logic             s_ack_i
);

  localparam int PW = (NM > 1) ? $clog2(NM) : 1;

  if (NM < 2 || NM > 8 || TIMEOUT_CYC < 1 || TIMEOUT_CYC > 65536) begin : g_param_check
    $error("regional_bus_arbiter: NM must be 2..8 and TIMEOUT_CYC 1..65536");
  end

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  state_e          state_q, state_d;
  logic [PW-1:0]   ptr_q, ptr_d;
  logic [PW-1:0]   g_q, g_d;
  logic            s_we_q, s_we_d;
  logic [31:0]     s_addr_q, s_addr_d;
  logic [31:0]     s_data_q, s_data_d;
  logic [31:0]     m_data_q, m_data_d;
  logic            tmo_hit;

`ifdef RBA_TIMEOUT_EN
  logic [15:0]     tmo_q, tmo_d;
  logic            err_q, err_d;

  assign tmo_hit = (tmo_q == 16'(TIMEOUT_CYC - 1));
`else
  assign tmo_hit = 1'b0;
`endif

  // ---------------------------------------------------------------------------
  // Round-robin pick: first requester at ptr, ptr+1, ... wrapping at NM, so
  // non-power-of-two NM never selects a nonexistent master.
  // ---------------------------------------------------------------------------
  logic          found;
  logic [PW-1:0] win;

  always_comb begin : arb_c
    int            idx_int;
    logic [PW-1:0] idx;
    // NOTE: every variable written here gets a default first; a path that
    // leaves one unassigned would infer a latch.
    found   = 1'b0;
    win     = '0;
    idx_int = 0;
    idx     = '0;
    for (int i = 0; i < NM; i++) begin
      idx_int = int'(ptr_q) + i;
      if (idx_int >= NM) idx_int = idx_int - NM;
      idx = PW'(idx_int);
      if (!found && m_req_i[idx]) begin
        found = 1'b1;
        win   = idx;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d  = state_q;
    ptr_d    = ptr_q;
    g_d      = g_q;
    s_we_d   = s_we_q;
    s_addr_d = s_addr_q;
    s_data_d = s_data_q;
    m_data_d = m_data_q;
`ifdef RBA_TIMEOUT_EN
    tmo_d    = tmo_q;
    err_d    = err_q;
`endif
    unique case (state_q)
      ST_IDLE: begin
        if (found) begin
          g_d      = win;
          s_we_d   = m_we_i[win];
          // Slice base is win*32; concatenation keeps the index exactly as
          // wide as the packed vector needs.
          s_addr_d = m_addr_i[{win, 5'b0} +: 32];
          s_data_d = m_data_i[{win, 5'b0} +: 32];
          state_d  = ST_BUSY;
`ifdef RBA_TIMEOUT_EN
          tmo_d    = '0;
          err_d    = 1'b0;
`endif
        end
      end
      ST_BUSY: begin
        // Ack takes precedence over the timeout in the terminal-count cycle.
        if (s_ack_i) begin
          m_data_d = s_data_i;
          state_d  = ST_RESP;
        end else if (tmo_hit) begin
          m_data_d = '0;
          state_d  = ST_RESP;
`ifdef RBA_TIMEOUT_EN
          err_d    = 1'b1;
`endif
        end else begin
`ifdef RBA_TIMEOUT_EN
          tmo_d    = tmo_q + 16'd1;
`endif
        end
      end
      ST_RESP: begin
        ptr_d   = (g_q == PW'(NM - 1)) ? '0 : g_q + 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------------
  // NOTE: all state here is control or directly visible on outputs, so every
  // register is reset; no storage is left unreset to save reset routing.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= ST_IDLE;
      ptr_q    <= '0;
      g_q      <= '0;
      s_we_q   <= 1'b0;
      s_addr_q <= '0;
      s_data_q <= '0;
      m_data_q <= '0;
`ifdef RBA_TIMEOUT_EN
      tmo_q    <= '0;
      err_q    <= 1'b0;
`endif
    end else begin
      // NOTE: non-blocking assignments so every register samples the
      // pre-edge values regardless of statement order.
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      g_q      <= g_d;
      s_we_q   <= s_we_d;
      s_addr_q <= s_addr_d;
      s_data_q <= s_data_d;
      m_data_q <= m_data_d;
`ifdef RBA_TIMEOUT_EN
      tmo_q    <= tmo_d;
      err_q    <= err_d;
`endif
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign s_req_o  = (state_q == ST_BUSY);
  assign s_we_o   = s_we_q;
  assign s_addr_o = s_addr_q;
  assign s_data_o = s_data_q;
  assign m_data_o = m_data_q;

  always_comb begin
    m_ack_o = '0;
    if (state_q == ST_RESP) m_ack_o[g_q] = 1'b1;
  end

`ifdef RBA_TIMEOUT_EN
  always_comb begin
    m_err_o = '0;
    if (state_q == ST_RESP && err_q) m_err_o[g_q] = 1'b1;
  end
`else
  assign m_err_o = '0;
`endif

endmodule

// File: tb/tb_regional_bus_arbiter.sv
// -----------------------------------------------------------------------------
// tb_regional_bus_arbiter
//
// Scoreboard bench. A transaction-level model predicts, from the master
// requests it drives, which master wins each arbitration (round robin with
// modular arithmetic) and which command must appear on the slave side; the
// slave model predicts the response each master must receive. A separate
// monitor compares DUT outputs against those queued predictions every cycle.
// Timeout scenarios are exercised when RBA_TIMEOUT_EN is defined.
// -----------------------------------------------------------------------------
module tb_regional_bus_arbiter;

  localparam int NM    = 3;
  localparam int TO    = 8;
  localparam int NEVER = 32'h7fff_ffff;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic [NM-1:0]    m_req_i, m_we_i, m_ack_o, m_err_o;
  logic [NM*32-1:0] m_addr_i, m_data_i;
  logic [31:0]      m_data_o, s_addr_o, s_data_o;
  logic [31:0]      s_data_i = '0;
  logic             s_req_o, s_we_o;
  logic             s_ack_i = 1'b0;

  regional_bus_arbiter #(.NM(NM), .TIMEOUT_CYC(TO)) dut (
    .clk      (clk),
    .rst      (rst),
    .m_req_i  (m_req_i),
    .m_we_i   (m_we_i),
    .m_addr_i (m_addr_i),
    .m_data_i (m_data_i),
    .m_data_o (m_data_o),
    .m_ack_o  (m_ack_o),
    .m_err_o  (m_err_o),
    .s_req_o  (s_req_o),
    .s_we_o   (s_we_o),
    .s_addr_o (s_addr_o),
    .s_data_o (s_data_o),
    .s_data_i (s_data_i),
    .s_ack_i  (s_ack_i)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- master-side stimulus state ----------------
  logic [NM-1:0] req_v  = '0;
  logic [NM-1:0] we_v   = '0;
  logic [NM-1:0] cont   = '0;   // re-request with a new command on ack
  logic          cont_we = 1'b0;
  logic [31:0]   addr_v [NM];
  logic [31:0]   data_v [NM];

  always_comb begin
    m_req_i  = req_v;
    m_we_i   = we_v;
    m_addr_i = '0;
    m_data_i = '0;
    for (int k = 0; k < NM; k++) begin
      m_addr_i[32*k +: 32] = addr_v[k];
      m_data_i[32*k +: 32] = data_v[k];
    end
  end

  // ---------------- scoreboard ----------------
  typedef struct { int cyc; logic we; logic [31:0] addr; logic [31:0] data; } cmd_t;
  typedef struct { int cyc; int g; logic [31:0] data; logic err; } rsp_t;
  typedef struct { logic [NM-1:0] ack; logic [NM-1:0] err; int cyc; } log_t;

  cmd_t s_q [$];
  rsp_t r_q [$];
  log_t ack_log [$];

  int n_vec  = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- reference model state ----------------
  int          rr       = 0;
  int          next_arb = 0;
  int          cur_g    = 0;
  int          arb_cyc  = 0;
  bit          s_active = 1'b0;
  int          s_idx    = 0;
  int          s_delay  = 0;
  int          forced_delay = -1;
  int          dmax     = 3;
  bit          never_ack = 1'b0;
  bit          force_data_en = 1'b0;
  logic [31:0] force_data = '0;

  task automatic model_reset();
    s_q.delete();
    r_q.delete();
    rr       = 0;
    next_arb = 0;
    s_active = 1'b0;
    s_ack_i  = 1'b0;
    req_v    = '0;
    cont     = '0;
  endtask

  // Slave: acks after a chosen number of BUSY cycles; the response the granted
  // master must see one cycle later is queued at that moment.
  task automatic slave_step();
    s_ack_i = 1'b0;
    if (!s_req_o) begin
      s_active = 1'b0;
      return;
    end
    if (!s_active) begin
      s_active = 1'b1;
      s_idx    = 0;
      s_delay  = (forced_delay >= 0) ? forced_delay : int'($urandom_range(dmax, 0));
    end else begin
      s_idx++;
    end
    if (!never_ack && s_idx == s_delay) begin
      s_ack_i  = 1'b1;
      s_data_i = force_data_en ? force_data : $urandom;
      r_q.push_back('{cyc + 1, cur_g, s_data_i, 1'b0});
      next_arb = cyc + 2;
    end
`ifdef RBA_TIMEOUT_EN
    else if (s_idx == TO - 1) begin
      r_q.push_back('{cyc + 1, cur_g, 32'h0, 1'b1});
      next_arb = cyc + 2;
    end
`endif
  endtask

  task automatic new_cmd(input int k, input logic we);
    req_v[k]  = 1'b1;
    we_v[k]   = we;
    addr_v[k] = $urandom;
    data_v[k] = $urandom;
  endtask

  task automatic drop_acked();
    for (int k = 0; k < NM; k++) begin
      if (m_ack_o[k]) begin
        if (cont[k]) new_cmd(k, cont_we);
        else req_v[k] = 1'b0;
      end
    end
  endtask

  // Arbitration: when the bus is free, the first requester found scanning
  // from the round-robin pointer wins; the pointer then moves past it.
  task automatic model_arb();
    if (cyc < next_arb) return;
    for (int i = 0; i < NM; i++) begin
      int k;
      k = (rr + i) % NM;
      if (req_v[k]) begin
        s_q.push_back('{cyc + 1, we_v[k], addr_v[k], data_v[k]});
        cur_g    = k;
        rr       = (k + 1) % NM;
        next_arb = NEVER;
        arb_cyc  = cyc;
        return;
      end
    end
  endtask

  task automatic step_pre();
    @(negedge clk);
    #1;
    slave_step();
    drop_acked();
  endtask

  task automatic step();
    step_pre();
    model_arb();
  endtask

  task automatic do_reset();
    step_pre();
    rst = 1'b0;
    model_reset();
    ack_log.delete();
    step_pre();
    rst = 1'b1;
    model_arb();
  endtask

  // ---------------- monitor ----------------
  cmd_t cur_cmd = '{0, 1'b0, 32'h0, 32'h0};
  logic prev_sreq = 1'b0;

  always @(negedge clk) begin
    if (!rst) begin
      prev_sreq = 1'b0;
    end else begin
      if (s_q.size() > 0 && s_q[0].cyc == cyc) begin
        check("s_req_rise", {prev_sreq, s_req_o}, 2'b01);
        cur_cmd = s_q.pop_front();
        check("s_cmd", {s_we_o, s_addr_o, s_data_o}, {cur_cmd.we, cur_cmd.addr, cur_cmd.data});
      end else if (s_req_o && !prev_sreq) begin
        check("s_req_unexpected", s_req_o, 1'b0);
      end else if (s_req_o) begin
        check("s_cmd_hold", {s_we_o, s_addr_o, s_data_o}, {cur_cmd.we, cur_cmd.addr, cur_cmd.data});
      end
      prev_sreq = s_req_o;

      if (m_ack_o != '0) ack_log.push_back('{m_ack_o, m_err_o, cyc});
      if (r_q.size() > 0 && r_q[0].cyc == cyc) begin
        rsp_t r;
        r = r_q.pop_front();
        check("m_ack", m_ack_o, NM'(1) << r.g);
        check("m_err", m_err_o, r.err ? (NM'(1) << r.g) : NM'(0));
        check("m_data", m_data_o, r.data);
      end else begin
        check("m_ack_quiet", {m_ack_o, m_err_o}, '0);
      end
    end
  end

  // ---------------- directed + random stimulus ----------------
  initial begin
    int t0;
    for (int k = 0; k < NM; k++) begin
      addr_v[k] = '0;
      data_v[k] = '0;
    end

    // Reset state
    repeat (2) @(negedge clk);
    check("rst_ctl", {s_req_o, s_we_o, m_ack_o, m_err_o}, '0);
    check("rst_data", {s_addr_o, s_data_o, m_data_o}, '0);
    #1 rst = 1'b1;

    // Single read from m0, same-cycle slave ack
    step_pre();
    forced_delay  = 0;
    force_data_en = 1'b1;
    force_data    = 32'hA5A5_0001;
    req_v[0] = 1'b1; we_v[0] = 1'b0; addr_v[0] = 32'h1000_0004; data_v[0] = 32'h0;
    model_arb();
    t0 = arb_cyc;
    repeat (4) step();
    check("t2_nacks", ack_log.size(), 1);
    if (ack_log.size() > 0) check("t2_ack", {ack_log[0].ack, ack_log[0].cyc}, {3'b001, t0 + 2});
    check("t2_data_hold", m_data_o, 32'hA5A5_0001);
    force_data_en = 1'b0;

    // m1 completes (pointer moves to 2), then reset while m2 is in BUSY
    step_pre();
    new_cmd(1, 1'b0);
    model_arb();
    repeat (4) step();
    step_pre();
    never_ack = 1'b1;
    new_cmd(2, 1'b1);
    model_arb();
    repeat (2) step();
    @(negedge clk);
    #1;
    check("t1_busy", s_req_o, 1'b1);
    rst = 1'b0;
    #1;
    check("t1_rst_ctl", {s_req_o, s_we_o, m_ack_o, m_err_o}, '0);
    check("t1_rst_data", {s_addr_o, s_data_o, m_data_o}, '0);
    model_reset();
    never_ack = 1'b0;
    ack_log.delete();
    step_pre();
    rst = 1'b1;
    new_cmd(1, 1'b0);
    new_cmd(2, 1'b0);
    model_arb();
    repeat (8) step();
    check("t1_nacks", ack_log.size(), 2);
    if (ack_log.size() > 0) check("t1_first", ack_log[0].ack, 3'b010);

    // All masters writing continuously, immediate ack
    do_reset();
    step_pre();
    cont = '1;
    cont_we = 1'b1;
    for (int k = 0; k < NM; k++) new_cmd(k, 1'b1);
    model_arb();
    repeat (20) step();
    cont = '0;
    repeat (6) step();
    check("t3_nacks_min", ack_log.size() >= 6, 1'b1);
    for (int i = 0; i < 6 && i < ack_log.size(); i++) begin
      check("t3_order", ack_log[i].ack, NM'(1) << (i % NM));
      if (i > 0) check("t3_spacing", ack_log[i].cyc - ack_log[i-1].cyc, 3);
    end

    // m2 arrives while m0 is busy; m0 re-requests on its ack; m0 addr churns
    do_reset();
    forced_delay = 3;
    step_pre();
    new_cmd(0, 1'b0);
    model_arb();
    step();
    step_pre();
    new_cmd(2, 1'b0);
    addr_v[0] = 32'hDEAD_0000;
    cont[0]   = 1'b1;
    cont_we   = 1'b0;
    model_arb();
    step_pre();
    addr_v[0] = 32'hBEEF_0000;
    model_arb();
    repeat (12) step();
    cont = '0;
    repeat (12) step();
    check("t4_nacks_min", ack_log.size() >= 3, 1'b1);
    if (ack_log.size() >= 3)
      check("t4_order", {ack_log[0].ack, ack_log[1].ack, ack_log[2].ack}, {3'b001, 3'b100, 3'b001});

`ifdef RBA_TIMEOUT_EN
    // Slave never acks: error response 8 cycles after s_req_o rises
    do_reset();
    never_ack = 1'b1;
    step_pre();
    new_cmd(1, 1'b0);
    model_arb();
    t0 = arb_cyc;
    repeat (12) step();
    never_ack = 1'b0;
    check("t5_nacks", ack_log.size(), 1);
    if (ack_log.size() > 0)
      check("t5_err", {ack_log[0].ack, ack_log[0].err, ack_log[0].cyc}, {3'b010, 3'b010, t0 + 1 + TO});
    check("t5_data", m_data_o, 32'h0);

    // Ack first arrives in the terminal-count cycle: ack wins, no error
    do_reset();
    forced_delay  = TO - 1;
    force_data_en = 1'b1;
    force_data    = 32'h1234_5678;
    step_pre();
    new_cmd(2, 1'b0);
    model_arb();
    repeat (12) step();
    force_data_en = 1'b0;
    check("t6_nacks", ack_log.size(), 1);
    if (ack_log.size() > 0) check("t6_noerr", {ack_log[0].ack, ack_log[0].err}, {3'b100, 3'b000});
    check("t6_data", m_data_o, 32'h1234_5678);
`endif

    // Randomized traffic: random requests, command churn while waiting,
    // random slave latency
    do_reset();
    forced_delay = -1;
    dmax = 3;
    for (int c = 0; c < 2000; c++) begin
      step_pre();
      for (int k = 0; k < NM; k++) begin
        if (!req_v[k] && $urandom_range(3, 0) == 0) new_cmd(k, 1'($urandom));
        else if (req_v[k] && $urandom_range(7, 0) == 0) begin
          addr_v[k] = $urandom;
          data_v[k] = $urandom;
        end
      end
      model_arb();
    end
    repeat (40) step();
    check("drain_reqs", req_v, '0);
    check("drain_queues", s_q.size() + r_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
